jump_ctrl: RTL and testbench
============================

// Module: jump_ctrl
// PURPOSE
//  Drives the PC's jump interface (absjump_en, target) from the decoded control-flow op.
//  Consumes prog_ctr from the PC and resolves JMP/BZ/CALL/RET into an absolute 10-bit target.
//  Targets come from a writable LUT; a hardware return-address stack serves CALL/RET.
//  Sits between the decoder and the PC; the PC samples absjump_en/target on the same clk edge.
// PARAMETERS
//  PC_W      10  width of prog_ctr/target
//  LUT_AW     5  LUT index width (2**LUT_AW entries)
//  RAS_DEPTH  4  return-address stack entries (power of 2, >=2)
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  reset       in   1      synchronous, active-low (reset==0 at posedge clears state)
//  op          in   3      cf_op_t: NONE=0, JMP=1, BZ=2, BNZ=3, CALL=4, RET=5 (6,7 = NONE)
//  lut_idx     in   LUT_AW LUT entry selecting target for JMP/BZ/BNZ/CALL
//  zero        in   1      ALU zero flag for BZ/BNZ
//  prog_ctr    in   PC_W   current PC value
//  lut_we      in   1      write LUT entry lut_widx with lut_wdata at posedge
//  lut_widx    in   LUT_AW LUT write index
//  lut_wdata   in   PC_W   LUT write data
//  absjump_en  out  1      PC loads target next edge
//  target      out  PC_W   absolute jump target
//  fault       out  1      sticky: RAS overflow/underflow occurred
//  ras_count   out  3      current stack occupancy 0..RAS_DEPTH
// BEHAVIOUR
//  - absjump_en/target combinational from op, zero, lut, RAS top, state; state registered.
//  - Reset (reset==0): ras_count=0, fault=0, state=RUN, LUT contents cleared to 0;
//    absjump_en=0 and target=0 while reset==0. Reset mid-op discards the op (no push/pop).
//  - States: RUN, FAULT. RUN->FAULT on CALL with ras_count==RAS_DEPTH or RET with ras_count==0.
//    FAULT->RUN only by reset. In FAULT: absjump_en=0, no push/pop, LUT writes still honoured.
//  - JMP: absjump_en=1, target=lut[lut_idx].
//  - BZ: absjump_en=zero; BNZ: absjump_en=~zero; target=lut[lut_idx] regardless of taken.
//  - CALL (not full): absjump_en=1, target=lut[lut_idx]; push prog_ctr+1 (mod 2**PC_W,
//    so 1023 pushes 0); ras_count+1 at edge.
//  - CALL when full: absjump_en=0, no push, fault set next edge.
//  - RET (not empty): absjump_en=1, target=RAS top; pop, ras_count-1 at edge.
//  - RET when empty: absjump_en=0, target=0, fault set next edge.
//  - NONE/undefined: absjump_en=0, target=0, no state change.
//  - LUT write and read of same index in same cycle: read returns OLD value (write at edge).
//  - Latency: target valid same cycle as op; PC reflects it after one posedge.
// STRUCTURE
//  - Package cf_pkg: typedef enum logic[2:0] cf_op_t; typedef enum logic cf_state_t {RUN,FAULT}.
//  - Sub-module ras_stack (push, pop, top, count, full, empty; parameter DEPTH, W);
//    top-level holds LUT, op decode, FSM.
// TESTING
//  1 Reset=0 two edges, then release -> absjump_en=0, target=0, ras_count=0, fault=0.
//  2 Write lut[3]=8; op=JMP idx=3 -> absjump_en=1, target=8 same cycle.
//  3 lut[5]=100; BZ idx=5 zero=0 -> en=0; zero=1 -> en=1, target=100; BNZ inverse.
//  4 prog_ctr=20 CALL idx=3 -> target=8, count=1; prog_ctr=9 RET -> target=21, count=0.
//  5 Five CALLs (DEPTH=4) -> 5th: en=0, fault=1 after edge; RET then -> en=0 (FAULT); reset clears.
//  6 prog_ctr=1023 CALL then RET -> RET target=0; RET at count=0 in RUN -> fault=1.

Source files
------------

// File: rtl/cf_pkg.sv
// Shared types and defaults for the control-flow jump controller.
package cf_pkg;

    localparam int PC_W      = 10;
    localparam int LUT_AW    = 5;
    localparam int RAS_DEPTH = 4;

    // Decoded control-flow operation; encodings 6 and 7 behave like OP_NONE.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_JMP  = 3'd1,
        OP_BZ   = 3'd2,
        OP_BNZ  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } cf_op_t;

    // RUN serves jumps normally; FAULT is left only through reset.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } cf_state_t;

    // Return address for a CALL: the instruction after the call, wrapping at the PC width.
    function automatic logic [PC_W-1:0] ret_addr(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Hardware return-address stack: push/pop one entry per cycle, top is combinational.
module ras_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 10,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [AW-1:0] top_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign top_idx = AW'(count_q - CW'(1));
    assign top     = empty ? '0 : mem_q[top_idx];

    // Next stack contents: a push writes the slot above the top, a pop just drops the count.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[count_q[AW-1:0]] = push_data;
            count_d                = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    // Stack registers, emptied by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Resolves JMP/BZ/BNZ/CALL/RET into an absolute PC target using a writable LUT and a return stack.
module jump_ctrl
    import cf_pkg::*;
#(
    parameter int PC_W_P      = PC_W,
    parameter int LUT_AW_P    = LUT_AW,
    parameter int RAS_DEPTH_P = RAS_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          op,
    input  logic [LUT_AW_P-1:0] lut_idx,
    input  logic                zero,
    input  logic [PC_W_P-1:0]   prog_ctr,
    input  logic                lut_we,
    input  logic [LUT_AW_P-1:0] lut_widx,
    input  logic [PC_W_P-1:0]   lut_wdata,
    output logic                absjump_en,
    output logic [PC_W_P-1:0]   target,
    output logic                fault,
    output logic [2:0]          ras_count
);

    localparam int LUT_N  = 2 ** LUT_AW_P;
    localparam int RAS_CW = $clog2(RAS_DEPTH_P) + 1;

    logic [PC_W_P-1:0] lut_q [LUT_N];
    logic [PC_W_P-1:0] lut_d [LUT_N];
    logic [PC_W_P-1:0] lut_rd;

    cf_state_t         state_q;
    cf_state_t         state_d;
    logic              fault_q;
    logic              fault_d;

    logic              ras_push;
    logic              ras_pop;
    logic              ras_full;
    logic              ras_empty;
    logic [PC_W_P-1:0] ras_top;
    logic [RAS_CW-1:0] ras_cnt;
    logic              fault_set;
    logic              run;

    ras_stack #(
        .DEPTH (RAS_DEPTH_P),
        .W     (PC_W_P)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr(prog_ctr)),
        .top       (ras_top),
        .count     (ras_cnt),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    assign run       = (state_q == RUN);
    assign lut_rd    = lut_q[lut_idx];
    assign fault     = fault_q;
    assign ras_count = 3'(ras_cnt);

    // Op decode: jump enable, target and stack requests; everything is suppressed while in reset.
    always_comb begin
        absjump_en = 1'b0;
        target     = '0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        fault_set  = 1'b0;
        if (reset) begin
            case (op)
                OP_JMP: begin
                    absjump_en = run;
                    target     = lut_rd;
                end
                OP_BZ: begin
                    absjump_en = run & zero;
                    target     = lut_rd;
                end
                OP_BNZ: begin
                    absjump_en = run & ~zero;
                    target     = lut_rd;
                end
                OP_CALL: begin
                    target = lut_rd;
                    if (run) begin
                        if (ras_full) begin
                            fault_set = 1'b1;
                        end else begin
                            absjump_en = 1'b1;
                            ras_push   = 1'b1;
                        end
                    end
                end
                OP_RET: begin
                    target = ras_top;
                    if (run) begin
                        if (ras_empty) begin
                            fault_set = 1'b1;
                        end else begin
                            absjump_en = 1'b1;
                            ras_pop    = 1'b1;
                        end
                    end
                end
                default: begin
                    absjump_en = 1'b0;
                    target     = '0;
                end
            endcase
        end
    end

    // A stack overflow or underflow latches the controller into FAULT until reset.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        if (fault_set) begin
            state_d = FAULT;
            fault_d = 1'b1;
        end
    end

    // LUT writes land at the edge, so a same-cycle read still sees the old entry.
    always_comb begin
        lut_d = lut_q;
        if (lut_we) begin
            lut_d[lut_widx] = lut_wdata;
        end
    end

    // FSM state and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // Target LUT storage, cleared on reset and writable in both RUN and FAULT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lut_q <= '{default: '0};
        end else begin
            lut_q <= lut_d;
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed scenarios then random ops against a queue-based model.
module tb_jump_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] op;
    logic [4:0] lut_idx;
    logic       zero;
    logic [9:0] prog_ctr;
    logic       lut_we;
    logic [4:0] lut_widx;
    logic [9:0] lut_wdata;
    logic       absjump_en;
    logic [9:0] target;
    logic       fault;
    logic [2:0] ras_count;

    int m_lut [32];
    int m_ras [$];
    bit m_fault;
    int total = 0;
    int bad   = 0;

    jump_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .lut_idx    (lut_idx),
        .zero       (zero),
        .prog_ctr   (prog_ctr),
        .lut_we     (lut_we),
        .lut_widx   (lut_widx),
        .lut_wdata  (lut_wdata),
        .absjump_en (absjump_en),
        .target     (target),
        .fault      (fault),
        .ras_count  (ras_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs mid-cycle, clock, update model, check state.
    task automatic apply_stimulus(input string tag, input bit rst, input int o, input int idx,
                                  input bit z, input int pc, input bit we, input int widx,
                                  input int wdata);
        bit exp_en;
        int exp_tgt;
        bit chk_tgt;
        reset     = rst;
        op        = 3'(o);
        lut_idx   = 5'(idx);
        zero      = z;
        prog_ctr  = 10'(pc);
        lut_we    = we;
        lut_widx  = 5'(widx);
        lut_wdata = 10'(wdata);
        #2;
        exp_en  = 1'b0;
        exp_tgt = 0;
        chk_tgt = 1'b1;
        if (!rst) begin
            exp_en = 1'b0;
        end else if (m_fault) begin
            chk_tgt = 1'b0;
        end else begin
            case (o)
                1: begin exp_en = 1'b1; exp_tgt = m_lut[idx]; end
                2: begin exp_en = z;    exp_tgt = m_lut[idx]; end
                3: begin exp_en = !z;   exp_tgt = m_lut[idx]; end
                4: begin
                    if (m_ras.size() == 4) chk_tgt = 1'b0;
                    else begin exp_en = 1'b1; exp_tgt = m_lut[idx]; end
                end
                5: begin
                    if (m_ras.size() != 0) begin exp_en = 1'b1; exp_tgt = m_ras[$]; end
                end
                default: ;
            endcase
        end
        check_output({tag, ".en"}, 32'(absjump_en), 32'(exp_en));
        if (chk_tgt) check_output({tag, ".target"}, 32'(target), 32'(exp_tgt));
        @(posedge clk);
        if (!rst) begin
            foreach (m_lut[i]) m_lut[i] = 0;
            m_ras.delete();
            m_fault = 1'b0;
        end else begin
            if (we) m_lut[widx] = wdata;
            if (!m_fault) begin
                if (o == 4) begin
                    if (m_ras.size() == 4) m_fault = 1'b1;
                    else m_ras.push_back((pc + 1) % 1024);
                end else if (o == 5) begin
                    if (m_ras.size() == 0) m_fault = 1'b1;
                    else void'(m_ras.pop_back());
                end
            end
        end
        #1;
        check_output({tag, ".count"}, 32'(ras_count), 32'(m_ras.size()));
        check_output({tag, ".fault"}, 32'(fault), 32'(m_fault));
    endtask

    initial begin
        $display("[TB] starting jump_ctrl bench");
        // reset and idle
        apply_stimulus("rst0", 0, 1, 0, 0, 0, 0, 0, 0);
        apply_stimulus("rst1", 0, 5, 0, 0, 0, 0, 0, 0);
        apply_stimulus("idle", 1, 0, 0, 0, 0, 0, 0, 0);
        // JMP through a freshly written entry, plus same-cycle write/read ordering
        apply_stimulus("wr3", 1, 0, 0, 0, 0, 1, 3, 8);
        apply_stimulus("jmp3", 1, 1, 3, 0, 0, 0, 0, 0);
        apply_stimulus("jmp_wr", 1, 1, 3, 0, 0, 1, 3, 77);
        apply_stimulus("jmp_new", 1, 1, 3, 0, 0, 1, 3, 8);
        // conditional branches
        apply_stimulus("wr5", 1, 0, 0, 0, 0, 1, 5, 100);
        apply_stimulus("bz_nt", 1, 2, 5, 0, 0, 0, 0, 0);
        apply_stimulus("bz_t", 1, 2, 5, 1, 0, 0, 0, 0);
        apply_stimulus("bnz_t", 1, 3, 5, 0, 0, 0, 0, 0);
        apply_stimulus("bnz_nt", 1, 3, 5, 1, 0, 0, 0, 0);
        // call / return pair
        apply_stimulus("call20", 1, 4, 3, 0, 20, 0, 0, 0);
        apply_stimulus("ret9", 1, 5, 0, 0, 9, 0, 0, 0);
        // overflow into FAULT, then reset
        for (int i = 0; i < 5; i++) apply_stimulus("call_ovf", 1, 4, 5, 0, 100 + i, 0, 0, 0);
        apply_stimulus("ret_flt", 1, 5, 0, 0, 0, 0, 0, 0);
        apply_stimulus("jmp_flt", 1, 1, 3, 0, 0, 1, 7, 55);
        apply_stimulus("rst_flt", 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus("post_rst", 1, 1, 3, 0, 0, 0, 0, 0);
        // PC wrap on push, then underflow
        apply_stimulus("call1023", 1, 4, 3, 0, 1023, 0, 0, 0);
        apply_stimulus("ret_wrap", 1, 5, 0, 0, 0, 0, 0, 0);
        apply_stimulus("ret_empty", 1, 5, 0, 0, 0, 0, 0, 0);
        apply_stimulus("undef6", 0, 6, 0, 0, 0, 0, 0, 0);
        apply_stimulus("undef7", 1, 7, 2, 1, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            bit rst;
            int pc;
            rst = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            pc  = ($urandom_range(0, 9) == 0) ? 1023 : int'($urandom_range(0, 1023));
            apply_stimulus("rand", rst, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), pc, ($urandom_range(0, 2) == 0),
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
